// File: rtl/arbiter_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package arbiter_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic [0:0] {
    S_IDLE,
    S_BUSY
  } state_e;

endpackage

// File: rtl/decoder_2_to_4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero while disabled.
module decoder_2_to_4 (
  input  logic       ena,
  input  logic [1:0] in,
  output logic [3:0] out
);

  always_comb begin
    out = '0;
    if (ena) begin
      unique case (in)
        2'd0:    out = 4'b0001;
        2'd1:    out = 4'b0010;
        2'd2:    out = 4'b0100;
        default: out = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/arbiter_4.sv
// Round-robin arbiter for four requesters with owner release and optional hold timeout.
module arbiter_4
  import arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output idx_t             grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned CntRaw = $clog2(MAX_HOLD + 1);
  localparam int unsigned CntW   = (CntRaw > 0) ? CntRaw : 1;
  localparam int unsigned HoldLastInt = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldLastInt);
  localparam bit TimeoutEn = (MAX_HOLD != 0);

  state_e          state_q, state_d;
  idx_t            grant_id_q, grant_id_d;
  idx_t            ptr_q, ptr_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;
  logic            release_owner;
  logic            release_timeout;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then add ptr back.
  function automatic idx_t rr_pick(input logic [N_REQ-1:0] r, input idx_t p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    idx_t               off;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
    return p + off;
  endfunction

  always_comb begin
    release_owner   = done[grant_id_q] || !req[grant_id_q];
    release_timeout = TimeoutEn && (hold_cnt_q == HoldLast);
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ena && (req != '0)) begin
          state_d    = S_BUSY;
          grant_id_d = rr_pick(req, ptr_q);
          hold_cnt_d = '0;
        end
      end
      S_BUSY: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + CntW'(1);
        if (release_owner || release_timeout) begin
          state_d = S_IDLE;
          ptr_d   = grant_id_q + 2'd1;
          // An owner release in the same cycle masks the timeout pulse.
          timeout_d = !release_owner;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign grant_id = grant_id_q;
  assign timeout  = timeout_q;

  decoder_2_to_4 u_decoder (
    .ena (busy),
    .in  (grant_id_q),
    .out (grant)
  );

endmodule

// File: doc/arbiter_4.md
# arbiter_4

Round-robin arbiter that shares one downstream resource among four requesters. It produces a one-hot grant through the existing 2-to-4 decoder, and holds that grant until the owner releases it or a hold timeout expires. It sits in front of any datapath that is selected by a 2-bit index and a 4-bit one-hot select. Typical use: bus or port muxing, where the decoder output drives the per-requester enables.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles a grant may be held before forced revocation; 0 disables the timeout.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ena  input  1  arbitration enable; low blocks new grants only.
- req  input  4  request lines, bit i = requester i, level-sensitive.
- done  input  4  release strobes; only the current owner's bit is honoured.
- grant  output  4  one-hot grant; all-zero when no owner.
- grant_id  output  2  index of the current owner; valid only while busy is high.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- State machine with two states:
  - S_IDLE: no owner; grant = 0, busy = 0.
  - S_BUSY: one owner; grant = one-hot of grant_id, busy = 1.
- Round-robin pointer `ptr` (2 bits) is the highest-priority index for the next arbitration.
- S_IDLE → S_BUSY when ena = 1 and req ≠ 0.
  - The winner is the first set bit of req, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The winner is registered into grant_id.
- S_BUSY → S_IDLE on any release condition, checked in this priority order:
  1. done[grant_id] = 1.
  2. req[grant_id] = 0 (requester withdrew).
  3. MAX_HOLD ≠ 0 and hold_cnt = MAX_HOLD−1. This condition alone asserts timeout for one cycle.
- On every exit from S_BUSY, ptr ← grant_id+1 (2-bit wrap, 3 → 0).
- done bits of non-owners are ignored at all times.
- ena = 0 while in S_BUSY does not abort the current grant; it only blocks the next one.
- hold_cnt:
  - cleared on entry to S_BUSY.
  - increments each cycle in S_BUSY.
  - width $clog2(MAX_HOLD+1), minimum 1.
  - saturates rather than wraps when MAX_HOLD = 0.
- Simultaneous done and timeout condition: treated as a normal release; timeout stays 0.
- Reset (async, any time):
  - outputs: grant = 0, grant_id = 0, busy = 0, timeout = 0.
  - internal: state S_IDLE, ptr = 0, hold_cnt = 0.
  - Outputs clear immediately on rst_n falling, without waiting for a clock edge.

## Timing
- Grant latency: req sampled high in S_IDLE at edge N → grant and busy high after edge N (visible in cycle N+1).
- Release latency: done sampled at edge M → grant = 0 after edge M.
- Mandatory gap: at least one cycle of grant = 0 between any two grants, including re-grant to the same requester. No overlapping or back-to-back one-hot grants.
- Max hold: with no release, grant stays high for exactly MAX_HOLD cycles. timeout is high in the first cycle after revocation.
- All outputs are registered or decoded from registers only; no combinational path from req/done to grant.

## Structure
- Shared package arbiter_pkg holds:
  - the state enum (S_IDLE, S_BUSY).
  - localparam N_REQ = 4.
  - the index type logic [1:0].
- Sub-module: decoder_2_to_4 instantiated once.
  - ena = busy, in = grant_id, out = grant.
  - This reuses the existing decoder rather than recoding the one-hot.
- Round-robin winner selection is a combinational function inside the block. Implement it as a rotate by ptr, a fixed-priority find-first, and an add-back of ptr.

## Test plan
- Reset then single request: req = 4'b0100 held, done pulsed after 3 granted cycles.
  - Expect grant = 4'b0100 and grant_id = 2 one cycle after req.
  - Expect grant = 0 after done; next ptr = 3.
- Fairness: req = 4'b1111 held; each owner pulses done after 1 cycle.
  - Expect grant_id sequence 0, 1, 2, 3, 0 with a 1-cycle grant = 0 gap between each.
- Timeout (MAX_HOLD = 4): req = 4'b0010 held, no done.
  - Expect grant = 4'b0010 for exactly 4 cycles, then a 1-cycle timeout pulse.
  - Expect the re-grant to requester 1 no sooner than 2 cycles after revocation.
- Boundary events:
  - done on a non-owner bit while busy → no effect.
  - done and timeout in the same cycle → release with timeout = 0.
  - owner drops req → release next edge.
- ena behaviour:
  - ena = 0 with req = 4'b1000 → grant stays 0.
  - ena dropped mid-grant → grant persists until done.
- Reset mid-grant: assert rst_n = 0 between clock edges while grant = 4'b0001.
  - Expect grant, busy and timeout = 0 without a clock edge.
  - After release, req = 4'b1111 grants index 0 (ptr reset to 0).
